// File: rtl/xf100_exu_alu_arb.sv
// Round-robin arbiter feeding the EXU's single ALU from two requesters, with a
// 2-entry writeback FIFO that backpressures both requesters when full.
module xf100_exu_alu_arb #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int INFO_W  = 16
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [INFO_W-1:0]  req0_info,
  input  logic [XLEN-1:0]    req0_rs1,
  input  logic [XLEN-1:0]    req0_rs2,
  input  logic               req0_rd_en,
  input  logic [RFIDX_W-1:0] req0_rdidx,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [INFO_W-1:0]  req1_info,
  input  logic [XLEN-1:0]    req1_rs1,
  input  logic [XLEN-1:0]    req1_rs2,
  input  logic               req1_rd_en,
  input  logic [RFIDX_W-1:0] req1_rdidx,

  output logic               alu_i_alu_op,
  output logic [INFO_W-1:0]  alu_i_alu_info,
  output logic [XLEN-1:0]    alu_i_rs1,
  output logic [XLEN-1:0]    alu_i_rs2,
  output logic               alu_i_rs1_en,
  output logic               alu_i_rs2_en,
  output logic               alu_i_rd_en,
  output logic [RFIDX_W-1:0] alu_i_rdidx,

  input  logic               alu_o_wbck_en,
  input  logic [XLEN-1:0]    alu_o_wbck_data,
  input  logic [RFIDX_W-1:0] alu_o_wbck_rdidx,

  output logic               wbck_valid,
  input  logic               wbck_ready,
  output logic [XLEN-1:0]    wbck_data,
  output logic [RFIDX_W-1:0] wbck_rdidx,
  output logic               wbck_src
);

  logic               r_rr_ptr;
  logic               r_wr_ptr;
  logic               r_rd_ptr;
  logic [1:0]         r_count;
  logic [XLEN-1:0]    r_fifo_data  [2];
  logic [RFIDX_W-1:0] r_fifo_rdidx [2];
  logic               r_fifo_src   [2];

  logic w_can_issue;
  logic w_gnt0;
  logic w_gnt1;
  logic w_any_gnt;
  logic w_push;
  logic w_pop;

  // Issue looks only at the registered count, so a pop frees a slot next cycle.
  assign w_can_issue = !rst && (r_count != 2'd2);
  assign w_gnt0      = w_can_issue && req0_valid && (!req1_valid || !r_rr_ptr);
  assign w_gnt1      = w_can_issue && req1_valid && (!req0_valid ||  r_rr_ptr);
  assign w_any_gnt   = w_gnt0 || w_gnt1;

  assign req0_ready  = w_gnt0;
  assign req1_ready  = w_gnt1;

  assign wbck_valid  = !rst && (r_count != 2'd0);
  assign wbck_data   = r_fifo_data[r_rd_ptr];
  assign wbck_rdidx  = r_fifo_rdidx[r_rd_ptr];
  assign wbck_src    = r_fifo_src[r_rd_ptr];

  assign w_push      = w_any_gnt && alu_o_wbck_en;
  assign w_pop       = wbck_valid && wbck_ready;

  always_comb begin
    alu_i_alu_op   = w_any_gnt;
    alu_i_rs1_en   = w_any_gnt;
    alu_i_rs2_en   = w_any_gnt;
    alu_i_alu_info = '0;
    alu_i_rs1      = '0;
    alu_i_rs2      = '0;
    alu_i_rd_en    = 1'b0;
    alu_i_rdidx    = '0;
    if (w_gnt0) begin
      alu_i_alu_info = req0_info;
      alu_i_rs1      = req0_rs1;
      alu_i_rs2      = req0_rs2;
      alu_i_rd_en    = req0_rd_en;
      alu_i_rdidx    = req0_rdidx;
    end else if (w_gnt1) begin
      alu_i_alu_info = req1_info;
      alu_i_rs1      = req1_rs1;
      alu_i_rs2      = req1_rs2;
      alu_i_rd_en    = req1_rd_en;
      alu_i_rdidx    = req1_rdidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      // Priority passes to the requester that was not just served.
      if (w_any_gnt) r_rr_ptr <= w_gnt0;
      if (w_push)    r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (!w_push && w_pop) r_count <= r_count - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr]  <= alu_o_wbck_data;
      r_fifo_rdidx[r_wr_ptr] <= alu_o_wbck_rdidx;
      r_fifo_src[r_wr_ptr]   <= w_gnt1;
    end
  end

endmodule

// File: tb/tb_xf100_exu_alu_arb.sv
// Directed bench for xf100_exu_alu_arb: a queue-based writeback model checked
// every cycle, plus hand-computed literal expectations for each scenario.
module tb_xf100_exu_alu_arb;

  localparam int XLEN    = 32;
  localparam int RFIDX_W = 5;
  localparam int INFO_W  = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               req0_valid, req0_ready, req0_rd_en;
  logic [INFO_W-1:0]  req0_info;
  logic [XLEN-1:0]    req0_rs1, req0_rs2;
  logic [RFIDX_W-1:0] req0_rdidx;
  logic               req1_valid, req1_ready, req1_rd_en;
  logic [INFO_W-1:0]  req1_info;
  logic [XLEN-1:0]    req1_rs1, req1_rs2;
  logic [RFIDX_W-1:0] req1_rdidx;
  logic               alu_i_alu_op, alu_i_rs1_en, alu_i_rs2_en, alu_i_rd_en;
  logic [INFO_W-1:0]  alu_i_alu_info;
  logic [XLEN-1:0]    alu_i_rs1, alu_i_rs2;
  logic [RFIDX_W-1:0] alu_i_rdidx;
  logic               alu_o_wbck_en;
  logic [XLEN-1:0]    alu_o_wbck_data;
  logic [RFIDX_W-1:0] alu_o_wbck_rdidx;
  logic               wbck_valid, wbck_ready, wbck_src;
  logic [XLEN-1:0]    wbck_data;
  logic [RFIDX_W-1:0] wbck_rdidx;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  xf100_exu_alu_arb #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_info(req0_info),
    .req0_rs1(req0_rs1), .req0_rs2(req0_rs2), .req0_rd_en(req0_rd_en), .req0_rdidx(req0_rdidx),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_info(req1_info),
    .req1_rs1(req1_rs1), .req1_rs2(req1_rs2), .req1_rd_en(req1_rd_en), .req1_rdidx(req1_rdidx),
    .alu_i_alu_op(alu_i_alu_op), .alu_i_alu_info(alu_i_alu_info),
    .alu_i_rs1(alu_i_rs1), .alu_i_rs2(alu_i_rs2),
    .alu_i_rs1_en(alu_i_rs1_en), .alu_i_rs2_en(alu_i_rs2_en),
    .alu_i_rd_en(alu_i_rd_en), .alu_i_rdidx(alu_i_rdidx),
    .alu_o_wbck_en(alu_o_wbck_en), .alu_o_wbck_data(alu_o_wbck_data),
    .alu_o_wbck_rdidx(alu_o_wbck_rdidx),
    .wbck_valid(wbck_valid), .wbck_ready(wbck_ready), .wbck_data(wbck_data),
    .wbck_rdidx(wbck_rdidx), .wbck_src(wbck_src)
  );

  // Stand-in ALU: every op is an add, writing back only when rd_en is set.
  assign alu_o_wbck_en    = alu_i_alu_op && alu_i_rd_en;
  assign alu_o_wbck_data  = alu_i_rs1 + alu_i_rs2;
  assign alu_o_wbck_rdidx = alu_i_rdidx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Writeback model: a queue of results in acceptance order, capped at two.
  typedef struct {
    logic [XLEN-1:0]    data;
    logic [RFIDX_W-1:0] idx;
    logic               src;
  } wb_t;

  wb_t  q[$];
  logic prio = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic can, g0, g1, hv;
    wb_t  e;
    can = !rst && (q.size() < 2);
    g0  = can && req0_valid && (!req1_valid || prio == 1'b0);
    g1  = can && req1_valid && (!req0_valid || prio == 1'b1);
    chk("ready0", req0_ready, g0);
    chk("ready1", req1_ready, g1);
    chk("alu_op", alu_i_alu_op, g0 || g1);
    if (g0 || g1) begin
      chk("alu_rs1",  alu_i_rs1,      g0 ? req0_rs1   : req1_rs1);
      chk("alu_rs2",  alu_i_rs2,      g0 ? req0_rs2   : req1_rs2);
      chk("alu_info", alu_i_alu_info, g0 ? req0_info  : req1_info);
      chk("alu_rden", alu_i_rd_en,    g0 ? req0_rd_en : req1_rd_en);
      chk("alu_idx",  alu_i_rdidx,    g0 ? req0_rdidx : req1_rdidx);
      chk("alu_en",   {alu_i_rs1_en, alu_i_rs2_en}, 2'b11);
    end else begin
      chk("idle_rs1", alu_i_rs1, 0);
      chk("idle_rs2", alu_i_rs2, 0);
      chk("idle_misc", {alu_i_alu_info, alu_i_rs1_en, alu_i_rs2_en, alu_i_rd_en, alu_i_rdidx}, 0);
    end
    hv = !rst && (q.size() != 0);
    chk("wbck_valid", wbck_valid, hv);
    if (hv) begin
      chk("wbck_data",  wbck_data,  q[0].data);
      chk("wbck_rdidx", wbck_rdidx, q[0].idx);
      chk("wbck_src",   wbck_src,   q[0].src);
    end
    if (rst) begin
      q.delete();
      prio = 1'b0;
    end else begin
      if (hv && wbck_ready) void'(q.pop_front());
      if (g0 && req0_rd_en) begin
        e.data = req0_rs1 + req0_rs2; e.idx = req0_rdidx; e.src = 1'b0; q.push_back(e);
      end
      if (g1 && req1_rd_en) begin
        e.data = req1_rs1 + req1_rs2; e.idx = req1_rdidx; e.src = 1'b1; q.push_back(e);
      end
      if (g0) prio = 1'b1;
      else if (g1) prio = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic rd, input logic [RFIDX_W-1:0] idx);
    req0_valid = v; req0_info = 16'h0001; req0_rs1 = a; req0_rs2 = b;
    req0_rd_en = rd; req0_rdidx = idx;
  endtask

  task automatic set1(input logic v, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic rd, input logic [RFIDX_W-1:0] idx);
    req1_valid = v; req1_info = 16'h0002; req1_rs1 = a; req1_rs2 = b;
    req1_rd_en = rd; req1_rdidx = idx;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin : stim
    rst = 1'b1;
    wbck_ready = 1'b1;
    set0(1'b1, 1, 2, 1'b1, 5'd1);
    set1(1'b0, 0, 0, 1'b0, 5'd0);

    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready0", req0_ready, 1'b0);
      chk("rst_wbv",    wbck_valid, 1'b0);
      cyc();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", req0_ready, 1'b1);
    cyc();
    set0(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("post_rst_wbv",  wbck_valid, 1'b1);
    chk("post_rst_data", wbck_data,  32'd3);
    cyc();

    // Single add op
    set0(1'b1, 5, 7, 1'b1, 5'd3);
    @(negedge clk);
    chk("single_op", alu_i_alu_op, 1'b1);
    cyc();
    set0(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("single_wbv", wbck_valid, 1'b1);
    chk("single_data", wbck_data, 32'd12);
    chk("single_idx", wbck_rdidx, 5'd3);
    chk("single_src", wbck_src, 1'b0);
    cyc();

    // Op without rd: consumed, nothing written back
    set1(1'b1, 9, 9, 1'b0, 5'd7);
    @(negedge clk);
    chk("nord_ready1", req1_ready, 1'b1);
    cyc();
    set1(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("nord_wbv", wbck_valid, 1'b0);
    cyc();

    // Round-robin with both requesters valid
    for (int k = 0; k < 4; k++) begin
      set0(1'b1, (k < 1) ? 10 : 20, 1, 1'b1, 5'd4);
      set1(1'b1, (k < 2) ? 100 : 200, 2, 1'b1, 5'd5);
      @(negedge clk);
      chk("rr_g0", req0_ready, (k % 2) == 0);
      chk("rr_g1", req1_ready, (k % 2) == 1);
      if (k > 0) chk("rr_src", wbck_src, ((k - 1) % 2) == 1);
      cyc();
    end
    set0(1'b0, 0, 0, 1'b0, 5'd0);
    set1(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("rr_src_last", wbck_src, 1'b1);
    chk("rr_data_last", wbck_data, 32'd202);
    cyc();

    // Writeback backpressure: fill, stall, then drain with one accept per pop
    begin
      int n;
      n = 0;
      wbck_ready = 1'b0;
      for (int c = 0; c < 10; c++) begin
        if (c == 4) wbck_ready = 1'b1;
        set0(1'b1, 1000 + n, 0, 1'b1, 5'(8 + n));
        @(negedge clk);
        if (c < 2)  chk("bp_accept", req0_ready, 1'b1);
        if (c == 2 || c == 3) chk("bp_stall", req0_ready, 1'b0);
        if (c == 4) begin
          chk("bp_pop_noissue", req0_ready, 1'b0);
          chk("bp_head0", wbck_data, 32'd1000);
        end
        if (c == 5) begin
          chk("bp_resume", req0_ready, 1'b1);
          chk("bp_head1", wbck_data, 32'd1001);
        end
        if (c < 2 || c >= 5) n++;
        cyc();
      end
      set0(1'b0, 0, 0, 1'b0, 5'd0);
      repeat (3) cyc();
    end

    // Reset while the FIFO is full
    wbck_ready = 1'b0;
    set0(1'b1, 50, 0, 1'b1, 5'd20);
    cyc();
    set0(1'b1, 51, 0, 1'b1, 5'd21);
    cyc();
    set0(1'b1, 52, 0, 1'b1, 5'd22);
    rst = 1'b1;
    @(negedge clk);
    chk("full_rst_ready0", req0_ready, 1'b0);
    chk("full_rst_wbv", wbck_valid, 1'b0);
    cyc();
    rst = 1'b0;
    wbck_ready = 1'b1;
    set0(1'b1, 60, 0, 1'b1, 5'd23);
    set1(1'b1, 70, 2, 1'b1, 5'd24);
    @(negedge clk);
    chk("rst_prio0", req0_ready, 1'b1);
    chk("rst_prio1", req1_ready, 1'b0);
    chk("rst_flushed", wbck_valid, 1'b0);
    cyc();
    set0(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("after_rst_g1", req1_ready, 1'b1);
    chk("after_rst_data", wbck_data, 32'd60);
    chk("after_rst_src", wbck_src, 1'b0);
    cyc();
    set1(1'b0, 0, 0, 1'b0, 5'd0);
    @(negedge clk);
    chk("after_rst_data2", wbck_data, 32'd72);
    chk("after_rst_src2", wbck_src, 1'b1);
    repeat (3) cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
